// File: rtl/ram_burst_ctrl.sv
// Burst sequencer owning the 64x8 single-port RAM port: write/read bursts with wrapping addresses.
// Optional zero-fill command compiled in with RAM_BURST_CLEAR_EN.
module ram_burst_ctrl #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
`ifdef RAM_BURST_CLEAR_EN
        S_RD_HOLD,
        S_CLEAR
`else
        S_RD_HOLD
`endif
    } state_e;

    localparam logic [AW-1:0] ONE = AW'(1);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] cnt_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_din_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic          done_q;
    logic          err_q;

    logic [AW-1:0] addr_inc_d;
    logic          last_d;

    assign addr_inc_d = addr_q + ONE;
    assign last_d     = (cnt_q == '0);

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ram_we_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        cnt_q  <= cmd_len;
                        unique case (cmd_op)
                            2'b00: state_q <= S_WRITE;
                            2'b01: begin
                                state_q    <= S_RD_ISSUE;
                                ram_addr_q <= cmd_addr;
                            end
`ifdef RAM_BURST_CLEAR_EN
                            2'b10: begin
                                state_q <= S_CLEAR;
                                addr_q  <= '0;
                                cnt_q   <= '1;
                            end
`endif
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        ram_din_q  <= wr_data;
                        addr_q     <= addr_inc_d;
                        cnt_q      <= cnt_q - ONE;
                        if (last_d) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: state_q <= S_RD_WAIT;
                S_RD_WAIT: begin
                    rd_data_q  <= ram_dout;
                    rd_valid_q <= 1'b1;
                    state_q    <= S_RD_HOLD;
                end
                S_RD_HOLD: begin
                    // ram_addr only moves on handshake, so a stall never re-targets the RAM
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (last_d) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q - ONE;
                            addr_q     <= addr_inc_d;
                            ram_addr_q <= addr_inc_d;
                            state_q    <= S_RD_ISSUE;
                        end
                    end
                end
`ifdef RAM_BURST_CLEAR_EN
                S_CLEAR: begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= addr_q;
                    ram_din_q  <= '0;
                    addr_q     <= addr_inc_d;
                    cnt_q      <= cnt_q - ONE;
                    if (last_d) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl with a RAM model and a flat-array
// reference of expected memory contents.
module tb_ram_burst_ctrl;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic          done;
    logic          err;

    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    logic [7:0] wbuf [64];
    int n_run;
    int n_fail;

    ram_burst_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port synchronous RAM; dout valid the cycle after a read address
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input int op, input int a, input int len);
        chk("cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_addr  = 6'(a);
        cmd_len   = 6'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input int a, input int len, input bit gaps);
        int ng;
        int ea;
        cmd(0, a, len);
        chk("wr_busy", int'(busy), 1);
        for (int i = 0; i <= len; i++) begin
            ng = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (ng) begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
                @(posedge clk); #1;
                chk("wr_gap_we", int'(ram_we), 0);
            end
            chk("wr_ready", int'(wr_ready), 1);
            wr_valid = 1'b1;
            wr_data  = wbuf[i];
            @(posedge clk); #1;
            ea = (a + i) % 64;
            chk("wr_we", int'(ram_we), 1);
            chk("wr_addr", int'(ram_addr), ea);
            chk("wr_din", int'(ram_din), int'(wbuf[i]));
            chk("wr_done", int'(done), (i == len) ? 1 : 0);
            ref_mem[ea] = wbuf[i];
        end
        wr_valid = 1'b0;
        chk("wr_end_busy", int'(busy), 0);
    endtask

    // stall_beat: -2 none, -1 random short stalls, >=0 that beat stalls stall_cyc
    task automatic rd_burst(input int a, input int len,
                            input int stall_beat, input int stall_cyc);
        int ea;
        int st;
        cmd(1, a, len);
        for (int b = 0; b <= len; b++) begin
            ea = (a + b) % 64;
            chk("rd_issue_v", int'(rd_valid), 0);
            chk("rd_addr", int'(ram_addr), ea);
            chk("rd_we", int'(ram_we), 0);
            @(posedge clk); #1;
            chk("rd_wait_v", int'(rd_valid), 0);
            @(posedge clk); #1;
            chk("rd_valid", int'(rd_valid), 1);
            chk("rd_data", int'(rd_data), int'(ref_mem[ea]));
            if (b == stall_beat) st = stall_cyc;
            else if (stall_beat == -1) st = int'($urandom_range(0, 2));
            else st = 0;
            repeat (st) begin
                rd_ready  = 1'b0;
                cmd_valid = 1'b1;
                cmd_op    = 2'b11;
                @(posedge clk); #1;
                chk("stall_v", int'(rd_valid), 1);
                chk("stall_data", int'(rd_data), int'(ref_mem[ea]));
                chk("stall_addr", int'(ram_addr), ea);
                chk("stall_err", int'(err), 0);
            end
            cmd_valid = 1'b0;
            rd_ready  = 1'b1;
            @(posedge clk); #1;
            rd_ready = 1'b0;
            chk("rd_hs_v", int'(rd_valid), 0);
            chk("rd_done", int'(done), (b == len) ? 1 : 0);
            chk("rd_busy", int'(busy), (b == len) ? 0 : 1);
        end
    endtask

    task automatic bad_op(input int op);
        cmd(op, 7, 3);
        chk("err_pulse", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_we", int'(ram_we), 0);
        @(posedge clk); #1;
        chk("err_clear", int'(err), 0);
        chk("err_done", int'(done), 0);
        chk("err_we2", int'(ram_we), 0);
    endtask

    initial begin
        int a;
        n_run     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_din", int'(ram_din), 0);
        chk("rst_rdv", int'(rd_valid), 0);
        chk("rst_rdd", int'(rd_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_cmd_ready", int'(cmd_ready), 1);
        chk("post_wr_ready", int'(wr_ready), 0);
        chk("post_we", int'(ram_we), 0);

        // full 64-beat wrapping write establishes known RAM contents
        for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
        wr_burst(int'($urandom_range(1, 63)), 63, 1'b0);

        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
        wr_burst(10, 2, 1'b0);
        rd_burst(10, 2, -2, 0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        wr_burst(62, 3, 1'b0);
        rd_burst(0, 1, -2, 0);

        rd_burst(10, 2, 1, 5);

        bad_op(3);

        // reset after two of four write beats
        a = int'($urandom_range(0, 63));
        for (int i = 0; i < 4; i++) wbuf[i] = ~ref_mem[(a + i) % 64];
        cmd(0, a, 3);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = wbuf[i];
            @(posedge clk); #1;
            chk("mr_we", int'(ram_we), 1);
            chk("mr_addr", int'(ram_addr), (a + i) % 64);
            ref_mem[(a + i) % 64] = wbuf[i];
        end
        wr_data = wbuf[2];
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_we_off", int'(ram_we), 0);
        chk("mr_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        chk("mr_wr_ignored", int'(ram_we), 0);
        chk("mr_done2", int'(done), 0);
        wr_valid = 1'b0;
        rd_burst(a, 3, -2, 0);

`ifdef RAM_BURST_CLEAR_EN
        cmd(2, 17, 5);
        chk("clr_accept_we", int'(ram_we), 0);
        chk("clr_busy", int'(busy), 1);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            chk("clr_we", int'(ram_we), 1);
            chk("clr_addr", int'(ram_addr), i);
            chk("clr_din", int'(ram_din), 0);
            chk("clr_done", int'(done), (i == 63) ? 1 : 0);
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        chk("clr_idle", int'(busy), 0);
        rd_burst(10, 0, -2, 0);
        rd_burst(60, 7, -2, 0);
`else
        bad_op(2);
        rd_burst(10, 2, -2, 0);
`endif

        for (int it = 0; it < 30; it++) begin
            int len;
            a = int'($urandom_range(0, 63));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 63))
                                              : int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) wbuf[i] = 8'($urandom);
                wr_burst(a, len, 1'b1);
            end else begin
                rd_burst(a, len, -1, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst sequencer that sits directly upstream of the 64 x 8 single-port `RAM` block and owns its `we`/`addr`/`din` inputs and its `dout` output. It accepts write-burst and read-burst commands over valid/ready handshakes and streams bytes in or out with auto-incrementing, wrapping addresses. An optional clear command zero-fills the RAM. This is the only master of the RAM port.

## Interface
- `AW`, 6: RAM address width; depth is 2^AW = 64.
- `DW`, 8: RAM data width.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted this cycle when both are high.
- `cmd_op` input 2: 00 = write burst, 01 = read burst, 10 = clear, 11 = reserved.
- `cmd_addr` input AW: start address.
- `cmd_len` input AW: burst length minus 1, so 0 to 63 means 1 to 64 beats.
- `wr_valid` / `wr_ready` / `wr_data`: input 1, output 1, input DW. Write-data stream.
- `rd_valid` / `rd_ready` / `rd_data`: output 1, input 1, output DW. Read-data stream.
- `ram_we` output 1: to RAM `we`.
- `ram_addr` output AW: to RAM `addr`.
- `ram_din` output DW: to RAM `din`.
- `ram_dout` input DW: from RAM `dout`. It is valid the cycle after `ram_addr` is presented with `ram_we` = 0.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when a command completes.
- `err` output 1: one-cycle pulse when a command is rejected.

## Operation
- **States:** IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, CLEAR.
- **Registered outputs:** all RAM-side outputs, `rd_data`, `rd_valid`, `done` and `err` are registered. `cmd_ready` and `wr_ready` decode directly from state.
- **IDLE:**
  - `cmd_ready` = 1.
  - On accept, latch the address counter from `cmd_addr` and the beat counter from `cmd_len`.
  - Op 00 goes to WRITE. Op 01 goes to RD_ISSUE, with `ram_addr` set to `cmd_addr`.
  - Op 10 goes to CLEAR, with address forced to 0 and count forced to 63.
  - Op 11 is accepted, pulses `err` the next cycle, and stays in IDLE.
- **WRITE:**
  - `wr_ready` = 1.
  - On each `wr_valid & wr_ready`, the next cycle drives `ram_we` = 1, `ram_addr` = counter and `ram_din` = `wr_data`.
  - The counter then increments mod 64.
  - On the last beat, go to IDLE and pulse `done` in the same cycle that `ram_we` is high for the final byte.
  - With no handshake, `ram_we` = 0.
- **RD_ISSUE:** present the address with `ram_we` = 0, then go to RD_WAIT.
- **RD_WAIT:** capture `ram_dout` into `rd_data`, set `rd_valid` = 1, then go to RD_HOLD.
- **RD_HOLD:**
  - Hold `rd_data` and `rd_valid` stable until `rd_ready`.
  - On handshake, clear `rd_valid`.
  - If beats remain, increment the address mod 64 and go to RD_ISSUE.
  - Otherwise pulse `done` and go to IDLE.
- **CLEAR:** `ram_we` = 1 and `ram_din` = 0 for addresses 0 to 63 on consecutive cycles, then `done` and IDLE.
- **Wrap-around:** a start address of 60 with `cmd_len` = 7 accesses 60, 61, 62, 63, 0, 1, 2, 3.
- **Input handling:** `wr_*` is ignored outside WRITE. `cmd_*` is ignored while `busy`.

## Timing
- **Reset values:** state IDLE; `ram_we`, `ram_addr`, `ram_din`, `rd_valid`, `rd_data`, `done`, `err` and `busy` all 0; `cmd_ready` = 1 and `wr_ready` = 0 in the cycle after reset.
- **Reset mid-burst:** `rst` mid-burst abandons the transfer at the next edge. RAM locations already written keep their data. No `done` is pulsed.
- **Write throughput:** 1 byte per cycle. The first byte can be accepted one cycle after command accept.
- **Write to RAM:** a byte handshaken at edge N is written into the RAM at edge N+1.
- **Read latency:** command accept at edge N gives `rd_valid` high in cycle N+3.
- **Read throughput:** with `rd_ready` held high, 3 cycles per byte.
- **Back-to-back commands:** a new command can be accepted in the cycle `done` is high. A read of an address whose write commits in that cycle returns the new data.
- **CLEAR duration:** 64 cycles of `ram_we` plus 1 accept cycle.

## Configuration
- **`RAM_BURST_CLEAR_EN` defined:** the CLEAR state and op 10 are implemented as described above.
- **`RAM_BURST_CLEAR_EN` undefined:** the CLEAR state is not compiled. Op 10 is handled like op 11: accepted, `err` pulses, no RAM access, no `done`.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> all outputs match their reset values, `cmd_ready` = 1, no `ram_we` pulse.
- **Write then read:**
  - Write burst at addr 10 with `cmd_len` = 2, data AA, BB, CC, `wr_valid` held high -> `ram_we` high for 3 consecutive cycles at addresses 10, 11, 12, with `done` on the third.
  - Then read the same range -> `rd_data` returns AA, BB, CC.
- **Wrap:** write addr 62 with `cmd_len` = 3, data 11, 22, 33, 44 -> addresses 62, 63, 0, 1. Reading addr 0 with `cmd_len` = 1 returns 33, 44.
- **Backpressure:** read burst of 3 with `rd_ready` low for 5 cycles on beat 2 -> `rd_data` stable and `rd_valid` high throughout the stall, no extra RAM read, correct order afterwards.
- **Reset mid-write:** assert `rst` after 2 of 4 write beats -> IDLE next cycle, no `done`. Read-back shows only the first 2 addresses updated.
- **Clear:** with `RAM_BURST_CLEAR_EN` defined, clear after writes -> 64 `ram_we` cycles with `ram_din` = 0 and a read of addr 10 returns 00. With the macro undefined, op 10 gives an `err` pulse and the data is unchanged.
